// File: rtl/laser_pkg.sv
// Shared constants and types for the LASER coverage-search scan controller.
package laser_pkg;

   localparam logic [5:0] NPTS = 6'd40;
   localparam logic [4:0] GRID = 5'd16;
   localparam logic [8:0] R_SQ = 9'd16;
   localparam logic [2:0] WIN  = 3'd2;

   typedef logic [3:0] coord_t;
   typedef logic [5:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      DRAIN = 3'd2,
      CMP   = 3'd3,
      SKIP  = 3'd4,
      FIN   = 3'd5
   } state_t;

   function automatic coord_t abs_diff(input coord_t a, input coord_t b);
      if (a >= b) begin
         abs_diff = a - b;
      end else begin
         abs_diff = b - a;
      end
   endfunction

endpackage

// File: rtl/laser_in_circle.sv
// Combinational coverage test: is point (px,py) within radius sqrt(R_SQ) of (cx,cy)?
module laser_in_circle
   import laser_pkg::*;
(
   input  logic [3:0] i_cx,
   input  logic [3:0] i_cy,
   input  logic [3:0] i_px,
   input  logic [3:0] i_py,
   output logic       o_hit
);

   logic [3:0] w_dx;
   logic [3:0] w_dy;
   logic [7:0] w_sq_x;
   logic [7:0] w_sq_y;
   logic [8:0] w_sum;

   // Squared distance compare; a 9-bit sum of two 8-bit squares cannot overflow.
   always_comb begin
      w_dx   = abs_diff(i_cx, i_px);
      w_dy   = abs_diff(i_cy, i_py);
      w_sq_x = {4'b0000, w_dx} * {4'b0000, w_dx};
      w_sq_y = {4'b0000, w_dy} * {4'b0000, w_dy};
      w_sum  = {1'b0, w_sq_x} + {1'b0, w_sq_y};
      o_hit  = (w_sum <= R_SQ);
   end

endmodule

// File: rtl/laser_scan_ctrl.sv
// Walks candidate centres (full grid or window around a seed), streams every point
// address per candidate, counts covered points and reports the best centre.
module laser_scan_ctrl
   import laser_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_mode,
   input  logic [3:0] i_seed_x,
   input  logic [3:0] i_seed_y,
   input  logic [3:0] i_other_x,
   input  logic [3:0] i_other_y,
   input  logic       i_other_en,
   output logic [5:0] o_pt_addr,
   input  logic [3:0] i_pt_x,
   input  logic [3:0] i_pt_y,
   output logic       o_busy,
   output logic       o_done,
   output logic [3:0] o_best_x,
   output logic [3:0] o_best_y,
   output logic [5:0] o_best_cnt
);

   localparam logic [5:0] GRID_W    = {1'b0, GRID};
   localparam logic [5:0] WIN_W     = {3'b000, WIN};
   localparam logic [5:0] LAST_ADDR = NPTS - 6'd1;

   state_t     r_state, w_state_nxt;
   logic [5:0] r_addr, w_addr_nxt;
   cnt_t       r_acc, w_acc_nxt, w_acc_inc;
   // Candidate coordinates are 6-bit two's complement so window edges never wrap.
   logic [5:0] r_cx, r_cy, r_x0, r_xe, r_ye;
   logic [5:0] w_cx_nxt, w_cy_nxt, w_x0_nxt, w_xe_nxt, w_ye_nxt;
   coord_t     r_ox, r_oy, w_ox_nxt, w_oy_nxt;
   logic       r_oen, w_oen_nxt;
   logic       r_busy, w_busy_nxt;
   logic       r_done, w_done_nxt;
   coord_t     r_best_x, r_best_y, w_bx_nxt, w_by_nxt;
   cnt_t       r_best_cnt, w_bc_nxt;

   logic [5:0] w_sx, w_sy, w_xe, w_ye, w_nx, w_ny;
   logic       w_svalid, w_nvalid, w_last, w_eval, w_inc;
   logic       w_hit_cand, w_hit_other;

   laser_in_circle u_hit_cand (
      .i_cx  (r_cx[3:0]),
      .i_cy  (r_cy[3:0]),
      .i_px  (i_pt_x),
      .i_py  (i_pt_y),
      .o_hit (w_hit_cand)
   );

   laser_in_circle u_hit_other (
      .i_cx  (r_ox),
      .i_cy  (r_oy),
      .i_px  (i_pt_x),
      .i_py  (i_pt_y),
      .o_hit (w_hit_other)
   );

   assign w_sx     = i_mode ? ({2'b00, i_seed_x} - WIN_W) : 6'd0;
   assign w_sy     = i_mode ? ({2'b00, i_seed_y} - WIN_W) : 6'd0;
   assign w_xe     = i_mode ? ({2'b00, i_seed_x} + WIN_W) : (GRID_W - 6'd1);
   assign w_ye     = i_mode ? ({2'b00, i_seed_y} + WIN_W) : (GRID_W - 6'd1);
   assign w_svalid = (w_sx < GRID_W) && (w_sy < GRID_W);

   assign w_last   = (r_cx == r_xe) && (r_cy == r_ye);
   assign w_nx     = (r_cx == r_xe) ? r_x0 : (r_cx + 6'd1);
   assign w_ny     = (r_cx == r_xe) ? (r_cy + 6'd1) : r_cy;
   assign w_nvalid = (w_nx < GRID_W) && (w_ny < GRID_W);

   // Point data lags the address by one cycle, so address 0 has nothing to evaluate yet.
   assign w_eval    = ((r_state == SCAN) && (r_addr != 6'd0)) || (r_state == DRAIN);
   assign w_inc     = w_eval && w_hit_cand && !(r_oen && w_hit_other);
   assign w_acc_inc = (w_inc && (r_acc != NPTS)) ? (r_acc + 6'd1) : r_acc;

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-register values.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_acc_nxt   = r_acc;
      w_cx_nxt    = r_cx;
      w_cy_nxt    = r_cy;
      w_x0_nxt    = r_x0;
      w_xe_nxt    = r_xe;
      w_ye_nxt    = r_ye;
      w_ox_nxt    = r_ox;
      w_oy_nxt    = r_oy;
      w_oen_nxt   = r_oen;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_bx_nxt    = r_best_x;
      w_by_nxt    = r_best_y;
      w_bc_nxt    = r_best_cnt;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_x0_nxt    = w_sx;
               w_xe_nxt    = w_xe;
               w_ye_nxt    = w_ye;
               w_cx_nxt    = w_sx;
               w_cy_nxt    = w_sy;
               w_ox_nxt    = i_other_x;
               w_oy_nxt    = i_other_y;
               w_oen_nxt   = i_other_en;
               w_bx_nxt    = 4'd0;
               w_by_nxt    = 4'd0;
               w_bc_nxt    = 6'd0;
               w_acc_nxt   = 6'd0;
               w_addr_nxt  = 6'd0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = w_svalid ? SCAN : SKIP;
            end else begin
               w_busy_nxt  = 1'b0;
            end
         end
         SCAN: begin
            w_acc_nxt = w_acc_inc;
            if (r_addr == LAST_ADDR) begin
               w_addr_nxt  = 6'd0;
               w_state_nxt = DRAIN;
            end else begin
               w_addr_nxt  = r_addr + 6'd1;
            end
         end
         DRAIN: begin
            w_acc_nxt   = w_acc_inc;
            w_state_nxt = CMP;
         end
         CMP: begin
            if (r_acc >= r_best_cnt) begin
               w_bx_nxt = r_cx[3:0];
               w_by_nxt = r_cy[3:0];
               w_bc_nxt = r_acc;
            end else begin
               w_bc_nxt = r_best_cnt;
            end
            w_acc_nxt = 6'd0;
            if (w_last) begin
               w_state_nxt = FIN;
               w_done_nxt  = 1'b1;
            end else begin
               w_cx_nxt    = w_nx;
               w_cy_nxt    = w_ny;
               w_state_nxt = w_nvalid ? SCAN : SKIP;
            end
         end
         SKIP: begin
            if (w_last) begin
               w_state_nxt = FIN;
               w_done_nxt  = 1'b1;
            end else begin
               w_cx_nxt    = w_nx;
               w_cy_nxt    = w_ny;
               w_state_nxt = w_nvalid ? SCAN : SKIP;
            end
         end
         FIN: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_addr_nxt  = 6'd0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr     <= 6'd0;
         r_acc      <= 6'd0;
         r_cx       <= 6'd0;
         r_cy       <= 6'd0;
         r_x0       <= 6'd0;
         r_xe       <= 6'd0;
         r_ye       <= 6'd0;
         r_ox       <= 4'd0;
         r_oy       <= 4'd0;
         r_oen      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_best_x   <= 4'd0;
         r_best_y   <= 4'd0;
         r_best_cnt <= 6'd0;
      end else begin
         r_addr     <= w_addr_nxt;
         r_acc      <= w_acc_nxt;
         r_cx       <= w_cx_nxt;
         r_cy       <= w_cy_nxt;
         r_x0       <= w_x0_nxt;
         r_xe       <= w_xe_nxt;
         r_ye       <= w_ye_nxt;
         r_ox       <= w_ox_nxt;
         r_oy       <= w_oy_nxt;
         r_oen      <= w_oen_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_best_x   <= w_bx_nxt;
         r_best_y   <= w_by_nxt;
         r_best_cnt <= w_bc_nxt;
      end
   end

   assign o_pt_addr  = r_addr;
   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_best_x   = r_best_x;
   assign o_best_y   = r_best_y;
   assign o_best_cnt = r_best_cnt;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Bench for laser_scan_ctrl: a per-cycle expectation queue built from a candidate-level
// model of the scan, plus directed scenarios pinned with hand-computed results.
module tb_laser_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       mode;
   logic [3:0] seed_x, seed_y, other_x, other_y;
   logic       other_en;
   logic [5:0] pt_addr;
   logic [3:0] pt_x, pt_y;
   logic       busy, done;
   logic [3:0] best_x, best_y;
   logic [5:0] best_cnt;

   int n_chk = 0;
   int n_pass = 0;

   logic [3:0] mem_x [64];
   logic [3:0] mem_y [64];

   typedef struct {
      bit busy;
      bit done;
      int addr;
      int bx;
      int by;
      int bc;
   } exp_t;

   exp_t exp_q [$];
   int held_x = 0, held_y = 0, held_c = 0;
   int m_lat, m_bx, m_by, m_bc;
   int lat;

   laser_scan_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_mode     (mode),
      .i_seed_x   (seed_x),
      .i_seed_y   (seed_y),
      .i_other_x  (other_x),
      .i_other_y  (other_y),
      .i_other_en (other_en),
      .o_pt_addr  (pt_addr),
      .i_pt_x     (pt_x),
      .i_pt_y     (pt_y),
      .o_busy     (busy),
      .o_done     (done),
      .o_best_x   (best_x),
      .o_best_y   (best_y),
      .o_best_cnt (best_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Point store: one-cycle read latency.
   always @(posedge clk) begin
      pt_x <= mem_x[pt_addr];
      pt_y <= mem_y[pt_addr];
   end

   function automatic bit covers(input int cx, input int cy, input int px, input int py);
      return ((cx - px) * (cx - px) + (cy - py) * (cy - py)) <= 16;
   endfunction

   function automatic exp_t mk_e(input bit b, input bit d, input int a,
                                 input int x, input int y, input int c);
      exp_t e;
      e.busy = b; e.done = d; e.addr = a; e.bx = x; e.by = y; e.bc = c;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
   endtask

   // Candidate-level model: each valid centre reads all 40 addresses then spends two
   // more cycles; each off-grid centre costs one idle-address cycle; then one DONE cycle.
   task automatic model_push(input bit md, input int sx, input int sy,
                             input int ox, input int oy, input bit oen);
      int xs, xe, ys, ye, n, c;
      if (md) begin
         xs = sx - 2; xe = sx + 2; ys = sy - 2; ye = sy + 2;
      end else begin
         xs = 0; xe = 15; ys = 0; ye = 15;
      end
      m_bx = 0; m_by = 0; m_bc = 0; n = 0;
      for (int y = ys; y <= ye; y++) begin
         for (int x = xs; x <= xe; x++) begin
            if (x < 0 || x > 15 || y < 0 || y > 15) begin
               exp_q.push_back(mk_e(1'b1, 1'b0, 0, 0, 0, 0));
               n++;
            end else begin
               c = 0;
               for (int p = 0; p < 40; p++) begin
                  if (covers(x, y, int'(mem_x[p]), int'(mem_y[p])) &&
                      !(oen && covers(ox, oy, int'(mem_x[p]), int'(mem_y[p]))))
                     c++;
               end
               for (int a = 0; a < 40; a++) exp_q.push_back(mk_e(1'b1, 1'b0, a, 0, 0, 0));
               exp_q.push_back(mk_e(1'b1, 1'b0, 0, 0, 0, 0));
               exp_q.push_back(mk_e(1'b1, 1'b0, 0, 0, 0, 0));
               n += 42;
               if (c >= m_bc) begin
                  m_bx = x; m_by = y; m_bc = c;
               end
            end
         end
      end
      exp_q.push_back(mk_e(1'b1, 1'b1, 0, m_bx, m_by, m_bc));
      m_lat = n;
   endtask

   // Per-cycle compare against the expectation queue (idle expectations when empty).
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk_e(1'b0, 1'b0, 0, held_x, held_y, held_c);
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("pt_addr", int'(pt_addr), e.addr);
      if (e.done) begin
         held_x = e.bx; held_y = e.by; held_c = e.bc;
      end
      if (e.done || !e.busy) begin
         chk("best_x", int'(best_x), e.bx);
         chk("best_y", int'(best_y), e.by);
         chk("best_cnt", int'(best_cnt), e.bc);
      end
   end

   task automatic fill(input int n_a, input int ax, input int ay, input int bx, input int by);
      for (int p = 0; p < 40; p++) begin
         mem_x[p] = (p < n_a) ? 4'(ax) : 4'(bx);
         mem_y[p] = (p < n_a) ? 4'(ay) : 4'(by);
      end
   endtask

   // extra_at: cycle index at which a spurious START is pulsed (-1 none, -2 the DONE cycle).
   task automatic run_scan(input bit md, input logic [3:0] sx, input logic [3:0] sy,
                           input logic [3:0] ox, input logic [3:0] oy, input bit oen,
                           input int extra_at, output int l);
      int ex;
      @(negedge clk); #1;
      mode = md; seed_x = sx; seed_y = sy; other_x = ox; other_y = oy; other_en = oen;
      start = 1'b1;
      model_push(md, int'(sx), int'(sy), int'(ox), int'(oy), oen);
      ex = (extra_at == -2) ? m_lat : extra_at;
      l = -1;
      for (int m = 0; m < 11000; m++) begin
         @(negedge clk); #1;
         start = (m == ex);
         if (m == ex) begin
            mode = ~md; seed_x = 4'($urandom_range(0, 15)); other_en = ~oen;
         end
         if (done) begin
            l = m;
            break;
         end
      end
      if (start) begin
         @(negedge clk); #1;
         start = 1'b0;
      end
      chk("scan latency vs model", l, m_lat);
      if (l < 0) exp_q.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0t, limit 5000000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; start = 1'b0; mode = 1'b0;
      seed_x = 4'd0; seed_y = 4'd0; other_x = 4'd0; other_y = 4'd0; other_en = 1'b0;
      for (int i = 0; i < 64; i++) begin
         mem_x[i] = 4'd0; mem_y[i] = 4'd0;
      end
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset pt_addr", int'(pt_addr), 0);
      chk("reset best_cnt", int'(best_cnt), 0);
      @(negedge clk); #1 rst_n = 1'b1;

      // 1: all points at (5,5); last raster centre within radius 4 wins ties
      fill(40, 5, 5, 5, 5);
      run_scan(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, -1, lat);
      chk("s1 latency", lat, 10752);
      chk("s1 model best_y", m_by, 9);
      chk("s1 best_x", int'(best_x), 5);
      chk("s1 best_y", int'(best_y), 9);
      chk("s1 best_cnt", int'(best_cnt), 40);

      // 2: every point excluded by the other circle
      run_scan(1'b0, 4'd0, 4'd0, 4'd5, 4'd5, 1'b1, -1, lat);
      chk("s2 latency", lat, 10752);
      chk("s2 model best_x", m_bx, 15);
      chk("s2 best_x", int'(best_x), 15);
      chk("s2 best_y", int'(best_y), 15);
      chk("s2 best_cnt", int'(best_cnt), 0);

      // 3: corner window, 16 skipped candidates
      fill(20, 1, 1, 12, 12);
      run_scan(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, -1, lat);
      chk("s3 latency", lat, 394);
      chk("s3 model cnt", m_bc, 20);
      chk("s3 best_x", int'(best_x), 2);
      chk("s3 best_y", int'(best_y), 2);
      chk("s3 best_cnt", int'(best_cnt), 20);

      // 4 and 5: centred window, then again with a START pulse while busy
      fill(25, 8, 8, 14, 14);
      for (int k = 0; k < 2; k++) begin
         run_scan(1'b1, 4'd8, 4'd8, 4'd0, 4'd0, 1'b0, (k == 0) ? -1 : 100, lat);
         chk("s4 latency", lat, 1050);
         chk("s4 best_x", int'(best_x), 10);
         chk("s4 best_y", int'(best_y), 10);
         chk("s4 best_cnt", int'(best_cnt), 25);
      end

      // 6: reset in the middle of a full scan
      fill(40, 5, 5, 5, 5);
      @(negedge clk); #1;
      mode = 1'b0; other_en = 1'b0; start = 1'b1;
      model_push(1'b0, 0, 0, 0, 0, 1'b0);
      for (int m = 0; m < 500; m++) begin
         @(negedge clk); #1;
         start = 1'b0;
      end
      rst_n = 1'b0;
      exp_q.delete();
      held_x = 0; held_y = 0; held_c = 0;
      #1;
      chk("abort pt_addr", int'(pt_addr), 0);
      chk("abort busy", int'(busy), 0);
      chk("abort done", int'(done), 0);
      chk("abort best_x", int'(best_x), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      for (int p = 0; p < 40; p++) begin
         mem_x[p] = 4'($urandom_range(0, 15));
         mem_y[p] = 4'($urandom_range(0, 15));
      end
      run_scan(1'b0, 4'd0, 4'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), -1, lat);
      chk("s6 restart latency", lat, 10752);

      // Randomized window scans with clustered points
      for (int it = 0; it < 8; it++) begin
         int cx, cy, v, sel, ex;
         cx = int'($urandom_range(0, 15));
         cy = int'($urandom_range(0, 15));
         for (int p = 0; p < 40; p++) begin
            v = cx + int'($urandom_range(0, 6)) - 3;
            if (v < 0) v = 0;
            if (v > 15) v = 15;
            mem_x[p] = 4'(v);
            v = cy + int'($urandom_range(0, 6)) - 3;
            if (v < 0) v = 0;
            if (v > 15) v = 15;
            mem_y[p] = 4'(v);
         end
         sel = int'($urandom_range(0, 2));
         ex = (sel == 0) ? -1 : ((sel == 1) ? int'($urandom_range(1, 200)) : -2);
         run_scan(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), ex, lat);
      end

      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
